pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the write-enable and flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC enable and PC source select.
- Resolves load-use stalls, taken branch/JAL redirects from MEM, multi-cycle data-memory waits, the SIIC/RTI exception sequence and halt.
- Pure control: it holds no datapath values beyond its own state, handler flag and stall counter.

Parameters:
REG_W, 3, register-index width (matches regsel)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_rs  in  REG_W  source reg A of the instruction in ID
id_rt  in  REG_W  source reg B of the instruction in ID
id_rs_use  in  1  instruction in ID reads id_rs
id_rt_use  in  1  instruction in ID reads id_rt
ex_memtoreg  in  1  instruction in EX is a load
ex_regwrite  in  1  instruction in EX writes a register
ex_regsel  in  REG_W  destination reg of the instruction in EX
mem_redirect  in  1  taken branch or JAL resolved in MEM
mem_access  in  1  instruction in MEM reads or writes data memory
mem_ready  in  1  data memory completes the access this cycle
mem_siic  in  1  SIIC instruction in MEM
mem_rti  in  1  RTI instruction in MEM
wb_halt  in  1  HALT in WB
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID register enable
idex_en  out  1  ID/EX register enable
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
ifid_flush  out  1  load a bubble into IF/ID
idex_flush  out  1  load a bubble into ID/EX
exmem_flush  out  1  load a bubble into EX/MEM
pc_sel  out  2  PC source: 00 seq, 01 redirect, 10 SIIC vector, 11 EPC
epc_we  out  1  capture the MEM-stage PC into EPC
in_handler  out  1  exception handler active
halted  out  1  pipeline permanently frozen
stall_cnt  out  CNT_W  saturating count of cycles in which pc_en=0

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, in_handler=0, halted=0, stall_cnt=0. Combinational outputs follow the RUN decode.
- FSM states:
  - RUN: normal operation.
  - MWAIT: data-memory access outstanding.
  - HALT: pipeline frozen.
- Default decode: all enables 1, all flushes 0, pc_sel=00, epc_we=0.
- Decode priority, highest first; only the first matching rule applies in a cycle.
- Rule 1, HALT state or wb_halt=1: all enables 0. Next state HALT, halted=1 from the next edge. Only reset exits HALT.
- Rule 2, mem_access=1 and mem_ready=0:
  - All enables 0 (full freeze), no flushes. Next state MWAIT.
  - In MWAIT, remain until mem_ready=1. That cycle decodes as RUN with rules 3-6 applied, and the next state is RUN.
  - Zero-wait access (mem_access=1 and mem_ready=1 in RUN): no stall.
- Rule 3, mem_siic=1 and in_handler=0:
  - ifid_flush, idex_flush and exmem_flush all 1.
  - epc_we=1, pc_sel=10; set in_handler.
  - mem_siic=1 with in_handler=1 is ignored (NOP).
- Rule 4, mem_rti=1 and in_handler=1:
  - Flush IF/ID, ID/EX and EX/MEM; pc_sel=11; clear in_handler.
  - RTI with in_handler=0 is a NOP.
- Rule 5, mem_redirect=1: flush IF/ID, ID/EX and EX/MEM; pc_sel=01. This overrides any load-use stall, because the dependent instruction is squashed.
- Rule 6, load-use hazard: ex_memtoreg & ex_regwrite & ((id_rs_use & id_rs==ex_regsel) | (id_rt_use & id_rt==ex_regsel)).
  - pc_en=0, ifid_en=0, idex_flush=1; other enables stay 1.
  - Exactly one bubble per hazard.
- A flush with enable=1 loads zeros/NOP; a flush never applies while its enable=0.
- stall_cnt increments on every edge with pc_en=0 and saturates at all-ones. It does not count in HALT.
- Reset mid-MWAIT or mid-HALT returns to RUN immediately; no pending access is remembered.

Decomposition:
- Shared package holds:
  - pc_sel encodings: PCSEL_SEQ, PCSEL_REDIR, PCSEL_VEC, PCSEL_EPC.
  - FSM state encoding.
  - REG_W.
- One natural sub-module, hazard_detect: combinational load-use compare, instantiated inside pipe_ctrl.

Test Plan:
- Load-use: EX ld to r3 (ex_memtoreg=1, ex_regsel=3), ID reads id_rs=3 with id_rs_use=1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
- Taken branch during a load-use hazard: mem_redirect=1 in the same cycle -> pc_sel=01, three flushes, pc_en=1, no stall.
- Memory wait: mem_access=1 with mem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, MWAIT->RUN on the ready cycle; stall_cnt=3.
- SIIC/RTI:
  - mem_siic -> epc_we=1, pc_sel=10, in_handler=1.
  - A second mem_siic -> ignored.
  - mem_rti -> pc_sel=11, in_handler=0.
- Halt: wb_halt=1 -> all enables 0 that cycle, halted=1 next edge and held despite mem_redirect or mem_siic. Driving rst=0 asynchronously -> halted=0, stall_cnt=0.
- Saturation: with CNT_W=4, 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
// Holds the PC source selects, the controller FSM states and the register-index width.
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    PCSEL_SEQ   = 2'b00,
    PCSEL_REDIR = 2'b01,
    PCSEL_VEC   = 2'b10,
    PCSEL_EPC   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MWAIT = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the instruction in ID.
module pipe_ctrl_hazard_detect #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_regsel,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_rs_use && (id_rs == ex_regsel);
  assign rt_match = id_rt_use && (id_rt == ex_regsel);
  assign load_use = ex_memtoreg && ex_regwrite && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: register enables/flushes,
// PC enable/source, memory-wait freeze, SIIC/RTI handler sequencing and halt.
module pipe_ctrl #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_regsel,
  input  logic             mem_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             mem_siic,
  input  logic             mem_rti,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       pc_sel,
  output logic             epc_we,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  import pipe_ctrl_pkg::*;

  state_e state;
  state_e state_nxt;
  logic   in_handler_nxt;
  logic   load_use;

  pipe_ctrl_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_use   (id_rs_use),
    .id_rt_use   (id_rt_use),
    .ex_memtoreg (ex_memtoreg),
    .ex_regwrite (ex_regwrite),
    .ex_regsel   (ex_regsel),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      in_handler <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      in_handler <= in_handler_nxt;
      // Frozen cycles after halt are not stalls; the count saturates rather than wraps.
      if ((state != ST_HALT) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign halted = (state == ST_HALT);

  // RUN and MWAIT share one decode: MWAIT only differs in that it re-evaluates
  // mem_ready each cycle, which the memory rule already does.
  always_comb begin
    state_nxt      = ST_RUN;
    in_handler_nxt = in_handler;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    pc_sel         = PCSEL_SEQ;
    epc_we         = 1'b0;

    if ((state == ST_HALT) || wb_halt) begin
      state_nxt = ST_HALT;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
    end else if (mem_access && !mem_ready) begin
      state_nxt = ST_MWAIT;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
    end else if (mem_siic && !in_handler) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      exmem_flush    = 1'b1;
      epc_we         = 1'b1;
      pc_sel         = PCSEL_VEC;
      in_handler_nxt = 1'b1;
    end else if (mem_rti && in_handler) begin
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
      exmem_flush    = 1'b1;
      pc_sel         = PCSEL_EPC;
      in_handler_nxt = 1'b0;
    end else if (mem_redirect) begin
      // The redirect squashes the dependent instruction, so any load-use stall is moot.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pc_sel      = PCSEL_REDIR;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all checked against
// an action-level reference model of the controller.
module tb_pipe_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_regsel;
  logic             id_rs_use, id_rt_use, ex_memtoreg, ex_regwrite;
  logic             mem_redirect, mem_access, mem_ready, mem_siic, mem_rti, wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       pc_sel;
  logic             epc_we, in_handler, halted;
  logic [CNT_W-1:0] stall_cnt;

  pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_regsel(ex_regsel),
    .mem_redirect(mem_redirect), .mem_access(mem_access), .mem_ready(mem_ready),
    .mem_siic(mem_siic), .mem_rti(mem_rti), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_sel(pc_sel), .epc_we(epc_we),
    .in_handler(in_handler), .halted(halted), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the pipeline should experience this cycle.
  typedef enum {ACT_NORMAL, ACT_HALT, ACT_MEMWAIT, ACT_TRAP, ACT_RETURN, ACT_REDIRECT, ACT_BUBBLE} act_e;

  bit m_halted;
  bit m_handler;
  int m_cnt;

  act_e       act;
  logic [4:0] exp_en;
  logic [2:0] exp_fl;
  logic [1:0] exp_sel;
  logic       exp_epc;

  function automatic bit reads_loaded_reg();
    logic [REG_W-1:0] srcs[2];
    bit               used[2];
    bit               hit = 0;
    srcs[0] = id_rs; used[0] = id_rs_use;
    srcs[1] = id_rt; used[1] = id_rt_use;
    if (!(ex_memtoreg && ex_regwrite)) return 0;
    foreach (srcs[i]) if (used[i] && srcs[i] == ex_regsel) hit = 1;
    return hit;
  endfunction

  task automatic predict();
    if (m_halted || wb_halt)               act = ACT_HALT;
    else if (mem_access && !mem_ready)     act = ACT_MEMWAIT;
    else if (mem_siic && !m_handler)       act = ACT_TRAP;
    else if (mem_rti && m_handler)         act = ACT_RETURN;
    else if (mem_redirect)                 act = ACT_REDIRECT;
    else if (reads_loaded_reg())           act = ACT_BUBBLE;
    else                                   act = ACT_NORMAL;
    // en bits: {pc, ifid, idex, exmem, memwb}; fl bits: {ifid, idex, exmem}
    case (act)
      ACT_HALT, ACT_MEMWAIT: begin exp_en = 5'b00000; exp_fl = 3'b000; exp_sel = 2'd0; end
      ACT_TRAP:     begin exp_en = 5'b11111; exp_fl = 3'b111; exp_sel = 2'd2; end
      ACT_RETURN:   begin exp_en = 5'b11111; exp_fl = 3'b111; exp_sel = 2'd3; end
      ACT_REDIRECT: begin exp_en = 5'b11111; exp_fl = 3'b111; exp_sel = 2'd1; end
      ACT_BUBBLE:   begin exp_en = 5'b00111; exp_fl = 3'b010; exp_sel = 2'd0; end
      default:      begin exp_en = 5'b11111; exp_fl = 3'b000; exp_sel = 2'd0; end
    endcase
    exp_epc = (act == ACT_TRAP);
  endtask

  task automatic advance_model();
    bool_update: begin
      if (!m_halted && !exp_en[4]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (act == ACT_HALT)   m_halted = 1;
      if (act == ACT_TRAP)   m_handler = 1;
      if (act == ACT_RETURN) m_handler = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, exp_en);
    check_eq("flushes", {ifid_flush, idex_flush, exmem_flush}, exp_fl);
    check_eq("pc_sel", pc_sel, exp_sel);
    check_eq("epc_we", epc_we, exp_epc);
    check_eq("in_handler", in_handler, m_handler);
    check_eq("halted", halted, m_halted);
    check_eq("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Inputs are held from just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    predict();
    compare_all();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_regsel = '0;
    id_rs_use = 0; id_rt_use = 0; ex_memtoreg = 0; ex_regwrite = 0;
    mem_redirect = 0; mem_access = 0; mem_ready = 1; mem_siic = 0; mem_rti = 0; wb_halt = 0;
  endtask

  // Asserts reset between clock edges and checks that it takes effect without a clock.
  task automatic do_reset();
    idle();
    #1 rst = 0;
    #1;
    check_eq("rst_halted", halted, 0);
    check_eq("rst_in_handler", in_handler, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    check_eq("rst_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    check_eq("rst_pc_sel", pc_sel, 2'd0);
    m_halted = 0; m_handler = 0; m_cnt = 0;
    @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use_r3();
    ex_memtoreg = 1; ex_regwrite = 1; ex_regsel = 3'd3;
    id_rs = 3'd3; id_rs_use = 1; id_rt = 3'd5; id_rt_use = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int halt_age;

  initial begin
    rst = 0;
    idle();
    m_halted = 0; m_handler = 0; m_cnt = 0;
    #12;
    check_eq("init_stall_cnt", stall_cnt, 0);
    check_eq("init_halted", halted, 0);
    @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;

    // Load-use: one bubble, then the load has moved on
    set_load_use_r3();
    cycle();
    ex_memtoreg = 0; ex_regwrite = 0;
    cycle();
    check_eq("lu_stall_cnt", stall_cnt, 1);

    // Redirect in the same cycle as a load-use hazard
    set_load_use_r3();
    mem_redirect = 1;
    cycle();
    check_eq("br_lu_stall_cnt", stall_cnt, 1);
    idle();
    cycle();

    // Three-cycle memory wait, then ready
    do_reset();
    mem_access = 1; mem_ready = 0;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    check_eq("mwait_stall_cnt", stall_cnt, 3);
    idle();
    cycle();

    // SIIC, ignored second SIIC, RTI, ignored stray RTI
    mem_siic = 1;
    cycle();
    check_eq("siic_in_handler", in_handler, 1);
    cycle();
    mem_siic = 0; mem_rti = 1;
    cycle();
    check_eq("rti_in_handler", in_handler, 0);
    cycle();
    idle();

    // Halt holds against redirect and SIIC, then async reset releases it
    wb_halt = 1;
    cycle();
    wb_halt = 0; mem_redirect = 1; mem_siic = 1;
    repeat (3) cycle();
    check_eq("halt_held", halted, 1);
    do_reset();

    // Saturation of the stall counter
    set_load_use_r3();
    repeat (20) cycle();
    check_eq("sat_stall_cnt", stall_cnt, CNT_MAX);
    do_reset();

    // Randomized traffic
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs        = REG_W'($urandom_range(0, 7));
      id_rt        = REG_W'($urandom_range(0, 7));
      ex_regsel    = REG_W'($urandom_range(0, 7));
      id_rs_use    = ($urandom_range(0, 3) != 0);
      id_rt_use    = ($urandom_range(0, 1) != 0);
      ex_memtoreg  = ($urandom_range(0, 2) == 0);
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      mem_access   = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 1) == 0);
      mem_siic     = ($urandom_range(0, 15) == 0);
      mem_rti      = ($urandom_range(0, 11) == 0);
      mem_redirect = ($urandom_range(0, 7) == 0);
      wb_halt      = ($urandom_range(0, 149) == 0);
      cycle();
      if (m_halted) halt_age++;
      if (halt_age >= 3) begin
        halt_age = 0;
        do_reset();
      end else if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
